// File: rtl/wb_regfile_pkg.sv
// Shared CPU package for the 16-bit pipeline: datapath widths and named
// architectural register indices used by writeback, decode and forwarding.
package wb_regfile_pkg;

    localparam int DATA_W   = 16;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 1 << ADDR_W;
    localparam int CNT_W    = 16;

    typedef logic [DATA_W-1:0] word_t;
    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef enum logic [ADDR_W-1:0] {
        R0 = 4'd0,
        R1 = 4'd1,
        R2 = 4'd2,
        R3 = 4'd3,
        R4 = 4'd4,
        R5 = 4'd5,
        R6 = 4'd6,
        R7 = 4'd7,
        SP = 4'd8,
        IH = 4'd9,
        RA = 4'd10,
        T  = 4'd11
    } reg_idx_e;

endpackage

// File: rtl/wb_mux.sv
// 2:1 writeback select (memory result vs ALU result). Shared with the
// forwarding unit so both consumers see the identical writeback value.
module wb_mux #(
    parameter int DATA_W = 16
) (
    input  logic              i_memtoreg,
    input  logic [DATA_W-1:0] i_alures,
    input  logic [DATA_W-1:0] i_memres,
    output logic [DATA_W-1:0] o_wb_data
);

    assign o_wb_data = i_memtoreg ? i_memres : i_alures;

endmodule

// File: rtl/wb_regfile.sv
// Writeback-stage register file: 16 entries, two async read ports, a debug
// port and a commit counter. Define WB_REGFILE_BYPASS_EN for write-to-read bypass.
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = wb_regfile_pkg::DATA_W,
    parameter int ADDR_W = wb_regfile_pkg::ADDR_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              memtoreg_i,
    input  logic [ADDR_W-1:0] regdst_i,
    input  logic              regwrite_i,
    input  logic [DATA_W-1:0] alures_i,
    input  logic [DATA_W-1:0] memres_i,
    input  logic [ADDR_W-1:0] rs_addr_i,
    input  logic [ADDR_W-1:0] rt_addr_i,
    output logic [DATA_W-1:0] rs_data_o,
    output logic [DATA_W-1:0] rt_data_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic [ADDR_W-1:0] dbg_addr_i,
    output logic [DATA_W-1:0] dbg_data_o,
    output logic [CNT_W-1:0]  wr_count_o
);

    localparam int N_REGS = 1 << ADDR_W;

    logic [DATA_W-1:0] r_regs [N_REGS];
    logic [CNT_W-1:0]  r_wr_count;
    logic [DATA_W-1:0] w_wb_data;

    wb_mux #(
        .DATA_W (DATA_W)
    ) u_wb_mux (
        .i_memtoreg (memtoreg_i),
        .i_alures   (alures_i),
        .i_memres   (memres_i),
        .o_wb_data  (w_wb_data)
    );

    // NOTE: the array is reset entry-by-entry because software relies on
    // every register reading zero after reset; this forces flops, not RAM.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < N_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_wr_count <= '0;
        end else if (regwrite_i) begin
            r_regs[regdst_i] <= w_wb_data;
            r_wr_count       <= r_wr_count + 1'b1;
        end
    end

    always_comb begin
        rs_data_o = r_regs[rs_addr_i];
        rt_data_o = r_regs[rt_addr_i];
`ifdef WB_REGFILE_BYPASS_EN
        // Bypass ignores reset: decode sees the in-flight value even though
        // the commit itself is suppressed.
        if (regwrite_i && (rs_addr_i == regdst_i)) begin
            rs_data_o = w_wb_data;
        end
        if (regwrite_i && (rt_addr_i == regdst_i)) begin
            rt_data_o = w_wb_data;
        end
`endif
    end

    assign dbg_data_o = r_regs[dbg_addr_i];
    assign wb_data_o  = w_wb_data;
    assign wr_count_o = r_wr_count;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile; expectations adapt to
// whether WB_REGFILE_BYPASS_EN is defined.
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        CLK = 1'b0;
    logic        RST;
    logic        memtoreg_i;
    logic [3:0]  regdst_i;
    logic        regwrite_i;
    logic [15:0] alures_i;
    logic [15:0] memres_i;
    logic [3:0]  rs_addr_i;
    logic [3:0]  rt_addr_i;
    logic [15:0] rs_data_o;
    logic [15:0] rt_data_o;
    logic [15:0] wb_data_o;
    logic [3:0]  dbg_addr_i;
    logic [15:0] dbg_data_o;
    logic [15:0] wr_count_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_count;

    wb_regfile dut (
        .CLK        (CLK),
        .RST        (RST),
        .memtoreg_i (memtoreg_i),
        .regdst_i   (regdst_i),
        .regwrite_i (regwrite_i),
        .alures_i   (alures_i),
        .memres_i   (memres_i),
        .rs_addr_i  (rs_addr_i),
        .rt_addr_i  (rt_addr_i),
        .rs_data_o  (rs_data_o),
        .rt_data_o  (rt_data_o),
        .wb_data_o  (wb_data_o),
        .dbg_addr_i (dbg_addr_i),
        .dbg_data_o (dbg_data_o),
        .wr_count_o (wr_count_o)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%04h expected 0x%04h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle past it.
    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic peek(input logic [3:0] idx, input string tag, input logic [15:0] exp);
        dbg_addr_i = idx;
        #1;
        check(tag, dbg_data_o, exp);
    endtask

    // One committed write of an ALU value.
    task automatic write_alu(input logic [3:0] idx, input logic [15:0] val);
        regwrite_i = 1'b1;
        memtoreg_i = 1'b0;
        regdst_i   = idx;
        alures_i   = val;
        tick();
        regwrite_i = 1'b0;
        exp_count++;
    endtask

    initial begin
        RST        = 1'b0;
        memtoreg_i = 1'b0;
        regdst_i   = '0;
        regwrite_i = 1'b0;
        alures_i   = '0;
        memres_i   = '0;
        rs_addr_i  = '0;
        rt_addr_i  = '0;
        dbg_addr_i = '0;
        exp_count  = '0;

        // Reset: whole array and counter read zero while held.
        tick();
        for (int i = 0; i < 16; i++) begin
            peek(i[3:0], $sformatf("reset_dbg[%0d]", i), 16'h0000);
        end
        check("reset_count", wr_count_o, 16'h0000);
        memtoreg_i = 1'b1;
        memres_i   = 16'h5A5A;
        #1;
        check("reset_wbdata_follows", wb_data_o, 16'h5A5A);
        @(negedge CLK);
        RST = 1'b1;

        // Writeback select: ALU path then memory path.
        regwrite_i = 1'b1;
        regdst_i   = 4'd3;
        memtoreg_i = 1'b0;
        alures_i   = 16'h1234;
        memres_i   = 16'hBEEF;
        #1;
        check("wbsel_alu_comb", wb_data_o, 16'h1234);
        tick();
        exp_count++;
        regwrite_i = 1'b0;
        peek(4'd3, "wbsel_alu_reg3", 16'h1234);
        check("wbsel_alu_count", wr_count_o, exp_count);

        regwrite_i = 1'b1;
        regdst_i   = 4'd4;
        memtoreg_i = 1'b1;
        #1;
        check("wbsel_mem_comb", wb_data_o, 16'hBEEF);
        tick();
        exp_count++;
        regwrite_i = 1'b0;
        peek(4'd4, "wbsel_mem_reg4", 16'hBEEF);
        check("wbsel_mem_count", wr_count_o, exp_count);

        // Write disabled for three edges.
        regdst_i   = 4'd3;
        memtoreg_i = 1'b0;
        alures_i   = 16'hFFFF;
        repeat (3) tick();
        peek(4'd3, "wrdis_reg3", 16'h1234);
        check("wrdis_count", wr_count_o, exp_count);

        // Independent read ports on different registers.
        rs_addr_i = 4'd3;
        rt_addr_i = 4'd4;
        #1;
        check("rdport_rs3", rs_data_o, 16'h1234);
        check("rdport_rt4", rt_data_o, 16'hBEEF);

        // Same-cycle hazard on register 5.
        rs_addr_i  = 4'd5;
        rt_addr_i  = 4'd5;
        dbg_addr_i = 4'd5;
        regwrite_i = 1'b1;
        regdst_i   = 4'd5;
        alures_i   = 16'hA5A5;
        #1;
        check("hazard_rs_pre", rs_data_o, BYPASS ? 16'hA5A5 : 16'h0000);
        check("hazard_rt_pre", rt_data_o, BYPASS ? 16'hA5A5 : 16'h0000);
        check("hazard_dbg_pre", dbg_data_o, 16'h0000);
        tick();
        exp_count++;
        regwrite_i = 1'b0;
        #1;
        check("hazard_rs_post", rs_data_o, 16'hA5A5);
        check("hazard_rt_post", rt_data_o, 16'hA5A5);
        check("hazard_dbg_post", dbg_data_o, 16'hA5A5);

        // Bypass must not trigger on a non-matching destination.
        rs_addr_i  = 4'd3;
        regwrite_i = 1'b1;
        regdst_i   = 4'd6;
        alures_i   = 16'h6666;
        #1;
        check("nobypass_rs3", rs_data_o, 16'h1234);
        regwrite_i = 1'b0;

        // Boundary indices: R0 is writable, R15 is the top entry.
        write_alu(4'd0, 16'h0F0F);
        write_alu(4'd15, 16'hF00D);
        peek(4'd0, "r0_writable", 16'h0F0F);
        peek(4'd15, "r15_write", 16'hF00D);
        peek(4'd14, "r14_untouched", 16'h0000);

        // Back-to-back writes: last one wins, two increments.
        regwrite_i = 1'b1;
        regdst_i   = 4'd2;
        alures_i   = 16'h1111;
        tick();
        alures_i   = 16'h2222;
        tick();
        regwrite_i = 1'b0;
        exp_count  = exp_count + 16'd2;
        peek(4'd2, "b2b_reg2", 16'h2222);
        check("b2b_count", wr_count_o, exp_count);

        // Reset pulsed across a write edge.
        regwrite_i = 1'b1;
        regdst_i   = 4'd7;
        memtoreg_i = 1'b0;
        alures_i   = 16'h7777;
        rs_addr_i  = 4'd7;
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("rstmid_bypass_rs", rs_data_o, BYPASS ? 16'h7777 : 16'h0000);
        peek(4'd3, "rstmid_reg3_cleared", 16'h0000);
        tick();
        peek(4'd7, "rstmid_reg7", 16'h0000);
        check("rstmid_count", wr_count_o, 16'h0000);
        exp_count = '0;
        @(negedge CLK);
        RST = 1'b1;
        tick();
        exp_count++;
        regwrite_i = 1'b0;
        peek(4'd7, "rstrel_reg7", 16'h7777);
        check("rstrel_count", wr_count_o, exp_count);

        // Counter wrap: fill to 0xFFFF, then one more write.
        regwrite_i = 1'b1;
        regdst_i   = 4'd1;
        alures_i   = 16'hC0DE;
        repeat (int'(16'hFFFF - exp_count)) tick();
        exp_count = 16'hFFFF;
        #1;
        check("wrap_count_max", wr_count_o, exp_count);
        tick();
        exp_count++;
        regwrite_i = 1'b0;
        check("wrap_count_zero", wr_count_o, exp_count);
        peek(4'd1, "wrap_reg1", 16'hC0DE);
        peek(4'd7, "wrap_reg7", 16'h7777);
        tick();
        check("wrap_count_idle", wr_count_o, 16'h0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
